// File: rtl/seven_seg_mux_ctrl.sv
// Multiplexed hex seven-segment driver: prescaled digit scan, shadowed display value,
// leading-zero blanking and PWM brightness on the anodes. Outputs are registered.
module seven_seg_mux_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned BIT_COUNT = 17
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [4*DIGITS-1:0]         value,
  input  logic                        load,
  input  logic                        lzb_en,
  input  logic [3:0]                  bright,
  output logic [DIGITS-1:0]           an,
  output logic [6:0]                  seg,
  output logic [$clog2(DIGITS)-1:0]   digit_idx
);

  localparam int unsigned     IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [BIT_COUNT-1:0] prescaler;
  logic                 tick;
  logic [IDX_W-1:0]     scanIdx;
  logic [4*DIGITS-1:0]  shadow;
  logic [3:0]           pwmPhase;
  logic                 lit;
  logic [DIGITS-1:0]    zeroAbove;
  logic [3:0]           curNib;
  logic                 blanked;
  logic                 showDigit;
  logic [DIGITS-1:0]    anNext;
  logic [6:0]           segNext;

  function automatic logic [6:0] hexGlyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign tick     = &prescaler;
  assign pwmPhase = prescaler[BIT_COUNT-1 -: 4];
  assign lit      = (bright == 4'hF) || (pwmPhase < bright);

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      scanIdx   <= '0;
      shadow    <= '0;
    end else begin
      prescaler <= prescaler + BIT_COUNT'(1);
      if (tick)
        scanIdx <= (scanIdx == LAST_IDX) ? '0 : scanIdx + IDX_W'(1);
      if (load)
        shadow <= value;
    end
  end

  // zeroAbove[i]: nibble i and every more-significant nibble are zero
  always_comb begin
    zeroAbove = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      zeroAbove[i] = ((shadow >> (4 * i)) == '0);
  end

  always_comb begin
    curNib  = '0;
    blanked = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == scanIdx) begin
        curNib  = shadow[4*i +: 4];
        blanked = lzb_en && (i != 0) && zeroAbove[i];
      end
    end
    showDigit = lit && !blanked;
    segNext   = showDigit ? hexGlyph(curNib) : '1;
    anNext    = '1;
    for (int unsigned i = 0; i < DIGITS; i++)
      anNext[i] = !(showDigit && (IDX_W'(i) == scanIdx));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      an        <= '1;
      seg       <= '1;
      digit_idx <= '0;
    end else begin
      an        <= anNext;
      seg       <= segNext;
      digit_idx <= scanIdx;
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// Bench for seven_seg_mux_ctrl: a 4-digit and a 3-digit instance driven together and
// compared each cycle against an arithmetic model of scan position, PWM and blanking.
module tb_seven_seg_mux_ctrl;

  localparam int unsigned BC     = 5;
  localparam int unsigned PERIOD = 1 << BC;

  logic        clock = 1'b0;
  logic        reset, load, lzbEn;
  logic [3:0]  bright;
  logic [15:0] value4;
  logic [11:0] value3;
  logic [3:0]  an4;
  logic [2:0]  an3;
  logic [6:0]  seg4, seg3;
  logic [1:0]  idx4, idx3;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned mdlN;
  logic [15:0] mdlShadow4;
  logic [11:0] mdlShadow3;

  logic [6:0] glyphTab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clock = ~clock;

  seven_seg_mux_ctrl #(.DIGITS(4), .BIT_COUNT(BC)) dut4 (
    .clock(clock), .reset(reset), .value(value4), .load(load), .lzb_en(lzbEn),
    .bright(bright), .an(an4), .seg(seg4), .digit_idx(idx4));

  seven_seg_mux_ctrl #(.DIGITS(3), .BIT_COUNT(BC)) dut3 (
    .clock(clock), .reset(reset), .value(value3), .load(load), .lzb_en(lzbEn),
    .bright(bright), .an(an3), .seg(seg3), .digit_idx(idx3));

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, mdlN);
    end
  endtask

  // Expected display after the next edge, from cycles since reset and the held value
  function automatic void model(input int unsigned d, input int unsigned n, input logic [15:0] sh,
                                output logic [7:0] an, output logic [6:0] sg, output logic [2:0] ix);
    int unsigned idx, p;
    logic [15:0] upper;
    bit show;
    idx   = (n / PERIOD) % d;
    p     = (n % PERIOD) / (PERIOD / 16);
    upper = sh >> (4 * idx);
    show  = ((bright == 4'd15) || (p < bright)) && !(lzbEn && idx >= 1 && upper == 16'h0);
    an    = 8'hFF;
    sg    = 7'h7F;
    if (show) begin
      an[idx] = 1'b0;
      sg      = glyphTab[upper[3:0]];
    end
    ix = 3'(idx);
  endfunction

  task automatic step(input bit rst, input bit ld, input logic [15:0] v);
    logic [7:0] eAn4, eAn3;
    logic [6:0] eSeg4, eSeg3;
    logic [2:0] eIx4, eIx3;
    reset  = rst;
    load   = ld;
    value4 = v;
    value3 = v[11:0];
    if (rst) begin
      eAn4 = 8'hFF; eAn3 = 8'hFF; eSeg4 = 7'h7F; eSeg3 = 7'h7F; eIx4 = '0; eIx3 = '0;
    end else begin
      model(4, mdlN, mdlShadow4, eAn4, eSeg4, eIx4);
      model(3, mdlN, {4'h0, mdlShadow3}, eAn3, eSeg3, eIx3);
    end
    @(posedge clock);
    #1;
    checkEq("an4", 32'(an4), 32'(eAn4[3:0]));
    checkEq("seg4", 32'(seg4), 32'(eSeg4));
    checkEq("idx4", 32'(idx4), 32'(eIx4));
    checkEq("an3", 32'(an3), 32'(eAn3[2:0]));
    checkEq("seg3", 32'(seg3), 32'(eSeg3));
    checkEq("idx3", 32'(idx3), 32'(eIx3));
    checkEq("an4OneHotLow", 32'($countones(~an4) <= 1), 32'd1);
    if (rst) begin
      mdlN = 0; mdlShadow4 = '0; mdlShadow3 = '0;
    end else begin
      mdlN++;
      if (ld) begin
        mdlShadow4 = v;
        mdlShadow3 = v[11:0];
      end
    end
    @(negedge clock);
  endtask

  task automatic runIdle(input int unsigned cycles);
    for (int unsigned k = 0; k < cycles; k++)
      step(1'b0, 1'b0, 16'($urandom));
  endtask

  function automatic logic [15:0] rndVal();
    logic [15:0] v;
    v = 16'($urandom);
    return v >> (4 * $urandom_range(0, 4));
  endfunction

  initial begin
    int unsigned cnt;
    reset = 1'b1; load = 1'b0; lzbEn = 1'b0; bright = 4'd15;
    value4 = '0; value3 = '0;
    mdlN = 0; mdlShadow4 = '0; mdlShadow3 = '0;
    @(negedge clock);
    step(1'b1, 1'b1, 16'hFFFF);
    step(1'b1, 1'b0, 16'h0000);

    // Scan cadence with 0x1234; also first post-reset cycles show glyph 0
    step(1'b0, 1'b1, 16'h1234);
    runIdle(5 * PERIOD);

    // Leading-zero blanking on and off
    lzbEn = 1'b1;
    step(1'b0, 1'b1, 16'h0007);
    runIdle(4 * PERIOD + 3);
    lzbEn = 1'b0;
    runIdle(4 * PERIOD);
    lzbEn = 1'b1;
    step(1'b0, 1'b1, 16'h0000);
    runIdle(4 * PERIOD);

    // PWM duty: count lit cycles of dut4 across one full scan
    bright = 4'd4;
    step(1'b0, 1'b1, 16'h8888);
    cnt = 0;
    for (int unsigned k = 0; k < 4 * PERIOD; k++) begin
      step(1'b0, 1'b0, 16'h0);
      if (an4 != 4'hF) cnt++;
    end
    checkEq("pwmLitCount", cnt, 4 * 8);
    bright = 4'd0;
    cnt = 0;
    for (int unsigned k = 0; k < 1000; k++) begin
      step(1'b0, 1'b0, 16'h0);
      if (an4 != 4'hF || an3 != 3'h7) cnt++;
    end
    checkEq("darkLitCount", cnt, 0);

    // Mid-scan reset
    bright = 4'd15;
    runIdle(PERIOD + 7);
    step(1'b1, 1'b0, 16'h0);
    runIdle(3);

    // Randomized traffic
    for (int unsigned k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 96) == 0) lzbEn = ~lzbEn;
      step($urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0, rndVal());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux_ctrl.md
SEVEN_SEG_MUX_CTRL -- requirements
Module: seven_seg_mux_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (legal range 2..8).
REQ-002 Parameter BIT_COUNT, default 17, prescaler width; legal minimum 5; benches SHALL override it with a small value.
REQ-003 Port clock, input, 1, single system clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port value, input, 4*DIGITS, hex nibbles; nibble i (bits 4i+3:4i) is digit i, with digit 0 the least significant.
REQ-006 Port load, input, 1, single-cycle strobe that captures value into the shadow register.
REQ-007 Port lzb_en, input, 1, enables leading-zero blanking.
REQ-008 Port bright, input, 4, PWM brightness duty for the anodes.
REQ-009 Port an, output, DIGITS, active-low digit anodes.
REQ-010 Port seg, output, 7, active-low segments in order {g,f,e,d,c,b,a}.
REQ-011 Port digit_idx, output, clog2(DIGITS), index of the digit currently being scanned.

Function
REQ-012 Prescaler: a BIT_COUNT-bit counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-013 tick SHALL be asserted in each cycle in which the prescaler equals all-ones.
REQ-014 Scan: digit_idx SHALL advance by 1 on each tick and wrap from DIGITS-1 to 0; the non-power-of-2 wrap SHALL be exact.
REQ-015 Shadow register: when load=1, shadow SHALL take value on that edge; when load=0, shadow SHALL hold.
REQ-016 A load change SHALL be visible on an/seg no later than 2 cycles after the load edge; tearing within a scan slot is permitted.
REQ-017 Decode: shadow nibble digit_idx SHALL map to hex glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 Leading-zero blanking: with lzb_en=1, digit i (i>=1) SHALL be blanked when nibble i and all more-significant nibbles are 0.
REQ-019 Digit 0 SHALL never be blanked by leading-zero blanking.
REQ-020 With lzb_en=0, no digit SHALL be blanked by leading-zero blanking.
REQ-021 PWM: let p = prescaler[BIT_COUNT-1:BIT_COUNT-4]. The anode is lit when bright==15 or p < bright; bright==0 SHALL keep every anode dark.
REQ-022 Lit digit: an SHALL drive bit digit_idx low and all other bits high, and seg SHALL drive the glyph.
REQ-023 Dark or blanked digit: an SHALL be all-ones and seg SHALL be 1111111.
REQ-024 Outputs an, seg and digit_idx SHALL be registered, so the outputs lag the internal scan state by exactly 1 cycle.
REQ-025 No two anode bits SHALL ever be low in the same cycle.

Reset
REQ-026 While reset=1, on the clock edge: prescaler=0, scan index=0, shadow=0, an=all-ones, seg=1111111, digit_idx=0.
REQ-027 Reset SHALL override load and abort any scan in progress.
REQ-028 On the first cycle after reset, with load=0, digit 0 SHALL show glyph 0, subject to PWM.
REQ-029 No output SHALL be X after one reset cycle.

Verification
REQ-030 Scan cadence (DIGITS=4, BIT_COUNT=5, bright=15, reset, load 0x1234) -> digit_idx steps 0,1,2,3,0 every 32 cycles; an steps 1110, 1101, 1011, 0111; seg shows 4, 3, 2, 1.
REQ-031 Leading-zero blanking (load 0x0007) -> with lzb_en=1, digits 3..1 dark (an=1111) and digit 0 shows 1111000; with lzb_en=0, digits 3..1 show 1000000.
REQ-032 All-zero value (load 0x0000, lzb_en=1) -> only digit 0 lit, showing 1000000.
REQ-033 PWM duty (bright=4, BIT_COUNT=5) -> an is low for 8 of 32 cycles per slot; bright=0 -> an stays 1111 for 1000 cycles.
REQ-034 Non-power-of-2 depth (DIGITS=3) -> digit_idx wraps 2->0 and index 3 is never seen; mid-scan reset -> next cycle an=111 and digit_idx=0.
REQ-035 Load strobe (value changes while load=0) -> display unchanged; after a load pulse the new glyph appears within 2 cycles.
